uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO_DEPTH-entry FIFO; a write to an idle, empty block puts its start bit on txd two cycles later.
// Writes are never stalled: a write while full is dropped and latches overflow; cts_n only gates the start of a frame.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 cts_n,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 rts,
  output logic                 busy,
  output logic                 txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(STOP_BITS * CLKS_PER_BIT) + 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 rts_q, rts_d;
  logic                 push, pop, start_ok;
  logic [DATA_BITS-1:0] head;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);
  assign rts      = rts_q;
  assign txd      = txd_q;
  assign head     = mem_q[rd_ptr_q];
  // full/empty come from the registered count, so a same-cycle pop never frees room for a write
  assign push     = wr_en & ~full;
  assign start_ok = ~empty & ~cts_n;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d    = ovf_q | (wr_en & full);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (start_ok) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) state_d = (PARITY != 0) ? PAR : STOP;
          else                    bit_d   = bit_q + 3'd1;
        end
      end
      PAR: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d = '0;
          if (start_ok) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // parity is fixed when the byte leaves the FIFO, before the shifter consumes it
    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ PAR_ODD;
    end
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PAR:     txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
    rts_d = (state_d != IDLE) | (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      rts_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      rts_q    <= rts_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (even/1 stop, odd/2 stop) share stimulus and are checked every cycle
// against a frame-level model (byte list + frame start time -> expected line level).
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, wr_en, cts_n;
  logic [7:0] wr_data;
  logic full0, empty0, ovf0, rts0, busy0, txd0;
  logic full1, empty1, ovf1, rts1, busy1, txd1;

  int n_cmp, n_err, cyc;
  int mq [2][8];
  int mn [2];
  bit fact [2];
  int fs [2];
  int fb [2];
  bit movf [2];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .cts_n(cts_n),
    .full(full0), .empty(empty0), .overflow(ovf0), .rts(rts0), .busy(busy0), .txd(txd0));

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .cts_n(cts_n),
    .full(full1), .empty(empty1), .overflow(ovf1), .rts(rts1), .busy(busy1), .txd(txd1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int par_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int flen(input int k);
    return (1 + 8 + 1 + ((k == 0) ? 1 : 2)) * CPB;
  endfunction

  // line level of bit slot i of a frame carrying byte b
  function automatic logic bitval(input int b, input int i, input int par);
    int ones;
    ones = $countones(b & 255);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && par != 0) return (par == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
    return 1'b1;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int  pre_n;
      bit  fr_on;
      if (!rst) begin
        mn[k] = 0; fact[k] = 1'b0; movf[k] = 1'b0;
      end else begin
        pre_n = mn[k];
        fr_on = fact[k] && (cyc <= fs[k] + flen(k) - 1);
        if (!fr_on && pre_n > 0 && !cts_n) begin
          fact[k] = 1'b1;
          fs[k]   = cyc;
          fb[k]   = mq[k][0];
          for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
          mn[k]--;
        end
        if (wr_en) begin
          if (pre_n == DEPTH) movf[k] = 1'b1;
          else begin
            mq[k][mn[k]] = int'(wr_data);
            mn[k]++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic       on, t;
      logic [5:0] e, g;
      on = rst && fact[k] && (cyc <= fs[k] + flen(k) - 1);
      t  = on ? bitval(fb[k], (cyc - fs[k]) / CPB, par_of(k)) : 1'b1;
      e  = {t, on, on || (mn[k] > 0), mn[k] == 0, mn[k] == DEPTH, movf[k]};
      if (k == 0) begin
        g = {txd0, busy0, rts0, empty0, full0, ovf0};
        chk("u0_txd_busy_rts_empty_full_ovf", 32'(g), 32'(e));
      end else begin
        g = {txd1, busy1, rts1, empty1, full1, ovf1};
        chk("u1_txd_busy_rts_empty_full_ovf", 32'(g), 32'(e));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, "_u0"}, 32'({txd0, busy0, rts0, empty0, full0, ovf0}), 32'(6'b100100));
    chk({tag, "_u1"}, 32'({txd1, busy1, rts1, empty1, full1, ovf1}), 32'(6'b100100));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin mn[k] = 0; fact[k] = 1'b0; movf[k] = 1'b0; fs[k] = 0; fb[k] = 0; end
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; cts_n = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_now("reset_state");
    idle(3);
    rst = 1'b1;
    idle(2);

    // single frames: 0x55 even parity / 0x01 odd parity shapes
    wr(8'h55);
    idle(60);
    wr(8'h01);
    idle(60);

    // back-to-back frames with no idle gap
    wr(8'hA5);
    wr(8'h3C);
    idle(120);

    // flow-controlled fill, overflow, then drain in order
    cts_n = 1'b1;
    for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
    idle(10);
    cts_n = 1'b0;
    idle(230);

    // cts_n raised mid-frame: current frame finishes, next byte is held
    wr(8'hC3);
    wr(8'h7E);
    idle(10);
    cts_n = 1'b1;
    idle(120);
    cts_n = 1'b0;
    idle(120);

    // randomized traffic with wandering cts_n
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 99) < 20);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 99) < 3) cts_n = ~cts_n;
      cycle();
    end
    wr_en = 1'b0; cts_n = 1'b0;
    idle(250);

    // asynchronous reset in the middle of a data bit with bytes still queued
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    idle(15);
    #1 rst = 1'b0;
    #1 chk_reset_now("async_reset");
    idle(2);
    rst = 1'b1;
    idle(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
